usb_in_ep_tx: RTL and testbench
===============================

Name: usb_in_ep_tx

Overview:
- Buffered bulk/interrupt IN-endpoint transmitter for the `usb` core: the device-to-host counterpart of the OUT receive queue path.
- Fabric logic pushes bytes into an internal FIFO. On each IN token addressed to EP_NUM, the block answers NAK (nothing queued), STALL, or a DATA packet of up to MAX_PKT bytes.
- It owns the DATA0/DATA1 toggle and retransmits unacknowledged packets.
- Sits beside the control-endpoint logic in `buffered_usb`; the top level muxes handshake/data_in/data_toggle by endpoint.

Parameters:
EP_NUM, 1, endpoint number served (1..15)
DEPTH, 64, FIFO depth in bytes, power of two, >= MAX_PKT
MAX_PKT, 64, maximum packet payload in bytes (8, 16, 32 or 64)

Ports:
clk  in  1  48 MHz system clock
rst  in  1  synchronous active-high reset
usb_rst  in  1  bus reset from usb core; same effect as rst
endpoint  in  4  token endpoint from core
direction_in  in  1  token is IN
setup  in  1  token is SETUP
transaction_active  in  1  core transaction in progress
data_strobe  in  1  core consumed current data_in byte
success  in  1  host ACKed the packet
ep_stall  in  1  level; answer STALL while high
clear_toggle  in  1  pulse; force next packet to DATA0
wr_data  in  8  byte to queue
wr_valid  in  1  write request
wr_ready  out  1  FIFO can accept a byte
data_in  out  8  byte presented to core
data_in_valid  out  1  more payload bytes remain in the current packet
data_toggle  out  1  PID selector, 0=DATA0, 1=DATA1
handshake  out  2  00 ack, 01 none, 10 nak, 11 stall
level  out  $clog2(DEPTH)+1  committed bytes queued

Behaviour:
Pointers and FIFO:
- wr_ptr, rd_ptr (committed) and tx_ptr (speculative), each $clog2(DEPTH)+1 bits, wrapping naturally.
- level = wr_ptr - rd_ptr.
- wr_ready = (level != DEPTH).
- Write when wr_valid && wr_ready. A write to a full FIFO is ignored.
- Writes are accepted in every state, including mid-packet. Bytes written after the packet starts are not added to that packet.

Reset (rst or usb_rst):
- Pointers 0; data_toggle 0; data_in 0; data_in_valid 0; handshake 2'b10 (NAK); state IDLE.
- Queued data is discarded.
- A reset mid-transaction aborts the packet, with no commit.

Token detection:
- start = rising edge of transaction_active (registered previous value) && endpoint==EP_NUM && direction_in && !setup.

State machine (IDLE, SEND, WAIT_END):
- IDLE
  - Every cycle: handshake <= ep_stall ? 11 : (level==0 ? 10 : 00).
  - On start with ep_stall or level==0: go to WAIT_END, no data.
  - On start otherwise:
    - pkt_len <= min(level, MAX_PKT); sent <= 0; tx_ptr <= rd_ptr.
    - data_in <= mem[rd_ptr]; data_in_valid <= 1; go to SEND.
  - Latency: data_in/data_in_valid valid 1 cycle after the start edge.
- SEND
  - On data_strobe: sent+1, tx_ptr+1, data_in <= mem[tx_ptr+1].
  - data_in_valid <= 0 in the same cycle that sent+1 == pkt_len.
  - On success: rd_ptr <= rd_ptr + pkt_len; data_toggle flips; go to WAIT_END.
  - On transaction_active low without success: no commit, toggle unchanged, data_in_valid <= 0, go to IDLE. The same bytes are resent on the next IN.
- WAIT_END
  - data_in_valid 0.
  - Return to IDLE when transaction_active is low.
- success and transaction_active falling in the same cycle: commit wins.

Toggle:
- clear_toggle sets data_toggle to 0 in IDLE.
- In SEND, clear_toggle is held pending and applied on return to IDLE. It overrides the flip from success.

Isolation:
- Tokens for other endpoints, SETUP tokens and OUT tokens never change any state.
- handshake is only meaningful to the top-level mux when endpoint==EP_NUM.

Optional Feature:
- USB_IN_ZLP_EN adds input flush (1-bit pulse).
- Defined:
  - flush sets zlp_pend.
  - An ACKed packet of length == MAX_PKT that leaves level==0 while zlp_pend is set arms a zero-length packet.
  - The next IN answers ACK with pkt_len=0 (data_in_valid never asserts). On success the toggle flips and zlp_pend clears.
  - A flush with level==0 and no armed ZLP clears immediately.
- Undefined: no flush port; no ZLPs are ever generated.

Decomposition:
- Package usb_pkg:
  - Handshake constants HS_ACK/HS_NONE/HS_NAK/HS_STALL.
  - Token PID constants.
  - The MAX_PKT legal set.
- One sub-module, `ep_fifo_ram`: DEPTH x 8 simple dual-port RAM with a registered read.
- All pointer/commit logic stays in usb_in_ep_tx.

Test Plan:
- Write 0x11,0x22,0x33 then IN to EP1 -> handshake 00, DATA0 payload 11 22 33, data_in_valid drops after 3rd strobe; success -> level 0, data_toggle 1.
- IN to EP1 with empty FIFO -> handshake 10; no data_in_valid; toggle and pointers unchanged.
- Queue 100 bytes (MAX_PKT=64), two INs each ACKed -> packets of 64 (DATA0) then 36 (DATA1); level 0.
- Queue 5 bytes, IN without success (transaction ends) -> level stays 5; next IN resends the same 5 bytes with the same toggle.
- ep_stall=1 with data queued, IN -> handshake 11, level unchanged. clear_toggle after an ACK -> next packet DATA0. usb_rst mid-SEND -> level 0, toggle 0, handshake 10.
- USB_IN_ZLP_EN: queue exactly 64 bytes, pulse flush, two INs both ACKed -> 64-byte DATA0, then zero-length DATA1; zlp_pend cleared.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared constants for the usb core: handshake codes, token PIDs,
// endpoint FSM encodings and the legal bulk/interrupt packet sizes.
package usb_pkg;

   localparam logic [1:0] HS_ACK   = 2'b00;
   localparam logic [1:0] HS_NONE  = 2'b01;
   localparam logic [1:0] HS_NAK   = 2'b10;
   localparam logic [1:0] HS_STALL = 2'b11;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SOF   = 4'b0101;
   localparam logic [3:0] PID_SETUP = 4'b1101;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_SEND     = 2'd1;
   localparam logic [1:0] ST_WAIT_END = 2'd2;

   function automatic logic max_pkt_legal(input int n);
      return (n == 8) || (n == 16) || (n == 32) || (n == 64);
   endfunction

endpackage

// File: rtl/ep_fifo_ram.sv
// DEPTH x 8 simple dual-port RAM, one write port, one registered read port.
// Ports: clk, rst (clears read register), we/waddr/wdata, re/raddr/rdata.
module ep_fifo_ram #(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [7:0]               wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [7:0]               rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // read register holds its value between reads so the core sees a stable byte
   always_ff @(posedge clk) begin
      if (rst)     rdata <= 8'h00;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/usb_in_ep_tx.sv
// Buffered bulk/interrupt IN endpoint: FIFO of fabric bytes answered to IN tokens
// with NAK, STALL or a DATA0/1 packet; uncommitted packets are resent.
// Ports: clk/rst/usb_rst, token info (endpoint, direction_in, setup,
// transaction_active), core feedback (data_strobe, success), ep_stall,
// clear_toggle, write side (wr_data/wr_valid/wr_ready), core side (data_in,
// data_in_valid, data_toggle, handshake), level.
// Optional macro USB_IN_ZLP_EN adds a flush input that terminates a transfer
// ending on a full-size packet with a zero-length packet.
module usb_in_ep_tx
   import usb_pkg::*;
#(
   parameter int EP_NUM  = 1,
   parameter int DEPTH   = 64,
   parameter int MAX_PKT = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   usb_rst,
   input  logic [3:0]             endpoint,
   input  logic                   direction_in,
   input  logic                   setup,
   input  logic                   transaction_active,
   input  logic                   data_strobe,
   input  logic                   success,
   input  logic                   ep_stall,
   input  logic                   clear_toggle,
`ifdef USB_IN_ZLP_EN
   input  logic                   flush,
`endif
   input  logic [7:0]             wr_data,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   output logic [7:0]             data_in,
   output logic                   data_in_valid,
   output logic                   data_toggle,
   output logic [1:0]             handshake,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic          srst;
   logic [1:0]    state;
   logic [PW-1:0] wr_ptr, rd_ptr, tx_ptr;
   logic [PW-1:0] pkt_len, sent, sent_nx;
   logic [PW-1:0] avail, nxt_len;
   logic          act_q, clr_pend, start, go_data;
   logic          wr_en, rd_en, zlp_arm;
   logic [AW-1:0] raddr;

   assign srst     = rst | usb_rst;
   assign level    = wr_ptr - rd_ptr;
   assign wr_ready = (level != PW'(DEPTH));
   assign wr_en    = wr_valid & wr_ready;
   assign start    = transaction_active & ~act_q & direction_in & ~setup
                   & (endpoint == 4'(EP_NUM));
   assign avail    = (level > PW'(MAX_PKT)) ? PW'(MAX_PKT) : level;
   assign nxt_len  = zlp_arm ? '0 : avail;
   assign go_data  = ~ep_stall & ((level != '0) | zlp_arm);
   assign sent_nx  = sent + 1'b1;

   // read the first byte on the token, then prefetch the next on each strobe
   always_comb begin
      rd_en = 1'b0;
      raddr = rd_ptr[AW-1:0];
      if (state == ST_IDLE && start && go_data) begin
         rd_en = 1'b1;
      end else if (state == ST_SEND && data_strobe && data_in_valid) begin
         rd_en = 1'b1;
         raddr = AW'(tx_ptr + 1'b1);
      end
   end

   ep_fifo_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .rst   (srst),
      .we    (wr_en),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (wr_data),
      .re    (rd_en),
      .raddr (raddr),
      .rdata (data_in)
   );

   always_ff @(posedge clk) begin
      // track the line through reset so a live transaction is not seen as new
      act_q <= transaction_active;
      if (srst) begin
         state         <= ST_IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         tx_ptr        <= '0;
         pkt_len       <= '0;
         sent          <= '0;
         data_toggle   <= 1'b0;
         data_in_valid <= 1'b0;
         handshake     <= HS_NAK;
         clr_pend      <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         unique case (state)
            ST_IDLE: begin
               if (ep_stall)                      handshake <= HS_STALL;
               else if (level == '0 && !zlp_arm)  handshake <= HS_NAK;
               else                               handshake <= HS_ACK;
               if (clear_toggle) data_toggle <= 1'b0;
               if (start) begin
                  if (go_data) begin
                     pkt_len       <= nxt_len;
                     sent          <= '0;
                     tx_ptr        <= rd_ptr;
                     data_in_valid <= (nxt_len != '0);
                     state         <= ST_SEND;
                  end else begin
                     state <= ST_WAIT_END;
                  end
               end
            end
            ST_SEND: begin
               if (clear_toggle) clr_pend <= 1'b1;
               if (data_strobe && data_in_valid) begin
                  sent   <= sent_nx;
                  tx_ptr <= tx_ptr + 1'b1;
                  if (sent_nx == pkt_len) data_in_valid <= 1'b0;
               end
               // commit wins over the end of the transaction
               if (success) begin
                  rd_ptr        <= rd_ptr + pkt_len;
                  data_toggle   <= ~data_toggle;
                  data_in_valid <= 1'b0;
                  state         <= ST_WAIT_END;
               end else if (!transaction_active) begin
                  data_in_valid <= 1'b0;
                  if (clr_pend || clear_toggle) data_toggle <= 1'b0;
                  clr_pend      <= 1'b0;
                  state         <= ST_IDLE;
               end
            end
            ST_WAIT_END: begin
               data_in_valid <= 1'b0;
               if (!transaction_active) begin
                  if (clr_pend || clear_toggle) data_toggle <= 1'b0;
                  clr_pend <= 1'b0;
                  state    <= ST_IDLE;
               end else if (clear_toggle) begin
                  clr_pend <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef USB_IN_ZLP_EN
   logic zlp_pend;
   logic zlp_arm_q;

   assign zlp_arm = zlp_arm_q;

   // a transfer that ends exactly on a full packet needs a ZLP to terminate
   always_ff @(posedge clk) begin
      if (srst) begin
         zlp_pend  <= 1'b0;
         zlp_arm_q <= 1'b0;
      end else if (state == ST_SEND && success) begin
         if (pkt_len == '0) begin
            zlp_pend  <= 1'b0;
            zlp_arm_q <= 1'b0;
         end else if (level == pkt_len) begin
            zlp_arm_q <= zlp_pend && (pkt_len == PW'(MAX_PKT));
            if (pkt_len != PW'(MAX_PKT)) zlp_pend <= 1'b0;
         end
      end else if (flush && (level != '0 || zlp_arm_q)) begin
         zlp_pend <= 1'b1;
      end
   end
`else
   assign zlp_arm = 1'b0;
`endif

endmodule

// File: tb/tb_usb_in_ep_tx.sv
// Directed bench for usb_in_ep_tx: byte scoreboard queue filled on writes,
// drained and compared as the endpoint presents IN packet payload.
module tb_usb_in_ep_tx;

   localparam int EP    = 1;
   localparam int DEPTH = 128;
   localparam int MAX   = 64;

   localparam logic [1:0] HS_ACK   = 2'b00;
   localparam logic [1:0] HS_NAK   = 2'b10;
   localparam logic [1:0] HS_STALL = 2'b11;

   logic       clk = 1'b0;
   logic       rst, usb_rst;
   logic [3:0] endpoint;
   logic       direction_in, setup, transaction_active;
   logic       data_strobe, success, ep_stall, clear_toggle;
   logic [7:0] wr_data;
   logic       wr_valid, wr_ready;
   logic [7:0] data_in;
   logic       data_in_valid, data_toggle;
   logic [1:0] handshake;
   logic [7:0] level;
`ifdef USB_IN_ZLP_EN
   logic       flush;
`endif

   int checks   = 0;
   int failures = 0;

   logic [7:0] sb [$];
   logic       tog_m  = 1'b0;
   logic       stall_m = 1'b0;
   logic       arm_m  = 1'b0;
   logic       pend_m = 1'b0;

   always #5 clk = ~clk;

   usb_in_ep_tx #(.EP_NUM(EP), .DEPTH(DEPTH), .MAX_PKT(MAX)) dut (
      .clk                (clk),
      .rst                (rst),
      .usb_rst            (usb_rst),
      .endpoint           (endpoint),
      .direction_in       (direction_in),
      .setup              (setup),
      .transaction_active (transaction_active),
      .data_strobe        (data_strobe),
      .success            (success),
      .ep_stall           (ep_stall),
      .clear_toggle       (clear_toggle),
`ifdef USB_IN_ZLP_EN
      .flush              (flush),
`endif
      .wr_data            (wr_data),
      .wr_valid           (wr_valid),
      .wr_ready           (wr_ready),
      .data_in            (data_in),
      .data_in_valid      (data_in_valid),
      .data_toggle        (data_toggle),
      .handshake          (handshake),
      .level              (level)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle();
      check("level", 32'(level), 32'(sb.size()));
      check("toggle", 32'(data_toggle), 32'(tog_m));
      check("valid_idle", 32'(data_in_valid), 32'd0);
   endtask

   task automatic wr_byte(input logic [7:0] b);
      wr_data  = b;
      wr_valid = 1'b1;
      if (sb.size() < DEPTH) sb.push_back(b);
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_toggle = 1'b1;
      @(posedge clk); #1;
      clear_toggle = 1'b0;
      tog_m = 1'b0;
   endtask

`ifdef USB_IN_ZLP_EN
   task automatic pulse_flush();
      flush = 1'b1;
      if (sb.size() != 0 || arm_m) pend_m = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask
`endif

   task automatic in_token(input logic [3:0] ep, input logic dir,
                           input logic stp, input logic ack,
                           input logic clr_mid);
      bit         mine;
      bit         zlp;
      int         n;
      int         cnt;
      logic [1:0] hs_exp;
      logic [7:0] b;
      mine = (ep == 4'(EP)) && dir && !stp;
      zlp  = arm_m;
      n    = (sb.size() > MAX) ? MAX : sb.size();
      if (zlp) n = 0;
      if (stall_m)                      hs_exp = HS_STALL;
      else if (sb.size() == 0 && !zlp)  hs_exp = HS_NAK;
      else                              hs_exp = HS_ACK;
      if (!mine || stall_m) n = 0;
      endpoint           = ep;
      direction_in       = dir;
      setup              = stp;
      transaction_active = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (mine) check("handshake", 32'(handshake), 32'(hs_exp));
      check("pkt_toggle", 32'(data_toggle), 32'(tog_m));
      cnt = 0;
      while (data_in_valid === 1'b1 && cnt < MAX + 4) begin
         b = (cnt < n) ? sb[cnt] : 8'h00;
         check($sformatf("byte%0d", cnt), 32'(data_in), 32'(b));
         @(posedge clk); #1;
         data_strobe = 1'b1;
         @(posedge clk); #1;
         data_strobe = 1'b0;
         cnt++;
         @(negedge clk);
      end
      check("pkt_len", 32'(cnt), 32'(n));
      @(posedge clk); #1;
      if (ack) begin
         success      = 1'b1;
         clear_toggle = clr_mid;
         @(posedge clk); #1;
         success      = 1'b0;
         clear_toggle = 1'b0;
      end
      transaction_active = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (ack && mine && hs_exp == HS_ACK) begin
         repeat (n) void'(sb.pop_front());
         tog_m = ~tog_m;
         if (zlp) begin
            arm_m  = 1'b0;
            pend_m = 1'b0;
         end else if (n == MAX && sb.size() == 0 && pend_m) begin
            arm_m = 1'b1;
         end else if (sb.size() == 0) begin
            pend_m = 1'b0;
         end
      end
      if (clr_mid) tog_m = 1'b0;
      check_idle();
   endtask

   initial begin
      rst = 1'b1; usb_rst = 1'b0;
      endpoint = 4'd0; direction_in = 1'b0; setup = 1'b0;
      transaction_active = 1'b0; data_strobe = 1'b0; success = 1'b0;
      ep_stall = 1'b0; clear_toggle = 1'b0;
      wr_data = 8'h00; wr_valid = 1'b0;
`ifdef USB_IN_ZLP_EN
      flush = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_level", 32'(level), 32'd0);
      check("rst_hs", 32'(handshake), 32'(HS_NAK));
      check("rst_toggle", 32'(data_toggle), 32'd0);
      check("rst_valid", 32'(data_in_valid), 32'd0);
      check("rst_data", 32'(data_in), 32'd0);
      check("rst_wr_ready", 32'(wr_ready), 32'd1);
      @(posedge clk); #1;

      wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
      in_token(4'd1, 1'b1, 1'b0, 1'b1, 1'b0);

      in_token(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);

      wr_byte(8'hA5); wr_byte(8'h5A);
      in_token(4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      in_token(4'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      in_token(4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      in_token(4'd1, 1'b1, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 100; i++) wr_byte(8'(i + 1));
      in_token(4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      in_token(4'd1, 1'b1, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 5; i++) wr_byte(8'(8'hC0 + i));
      in_token(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      in_token(4'd1, 1'b1, 1'b0, 1'b1, 1'b0);

      wr_byte(8'h71); wr_byte(8'h72);
      ep_stall = 1'b1; stall_m = 1'b1;
      in_token(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      ep_stall = 1'b0; stall_m = 1'b0;
      in_token(4'd1, 1'b1, 1'b0, 1'b1, 1'b0);

      wr_byte(8'h81);
      in_token(4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      pulse_clear();
      check("clear_idle", 32'(data_toggle), 32'(tog_m));
      wr_byte(8'h82);
      in_token(4'd1, 1'b1, 1'b0, 1'b1, 1'b1);
      wr_byte(8'h83);
      in_token(4'd1, 1'b1, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < DEPTH + 1; i++) wr_byte(8'(i ^ 8'h3C));
      check("full_wr_ready", 32'(wr_ready), 32'(sb.size() < DEPTH));
      check("full_level", 32'(level), 32'(DEPTH));
      in_token(4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      in_token(4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      in_token(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);

      wr_byte(8'h91); wr_byte(8'h92); wr_byte(8'h93);
      endpoint = 4'd1; direction_in = 1'b1; setup = 1'b0;
      transaction_active = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("ur_valid", 32'(data_in_valid), 32'd1);
      @(posedge clk); #1;
      data_strobe = 1'b1;
      @(posedge clk); #1;
      data_strobe = 1'b0;
      usb_rst = 1'b1;
      @(posedge clk); #1;
      usb_rst = 1'b0;
      transaction_active = 1'b0;
      sb.delete();
      tog_m = 1'b0;
      @(negedge clk);
      check("ur_hs", 32'(handshake), 32'(HS_NAK));
      check_idle();
      @(posedge clk); #1;
      @(posedge clk); #1;
      wr_byte(8'hA1);
      in_token(4'd1, 1'b1, 1'b0, 1'b1, 1'b0);

`ifdef USB_IN_ZLP_EN
      pulse_clear();
      for (int i = 0; i < MAX; i++) wr_byte(8'(i + 8'h40));
      pulse_flush();
      in_token(4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      check("zlp_armed", 32'(arm_m), 32'd1);
      in_token(4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      in_token(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
